burst_addr_gen: RTL and testbench

//  Second-generation burst controller. Serially loads a burst length and start address, then issues
//  the burst address sequence on a valid/ready handshake to the memory-side address path.

---
 rtl/burst_addr_gen.sv | 96 +++++++++
 tb/tb_burst_addr_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: serially loads a burst length and start address, then issues single/incr/wrap burst addresses over valid/ready
module burst_addr_gen #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4,
   parameter int STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic              ser_in,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic              last,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int BW = $clog2(ADDR_W);
   localparam int SH = $clog2(STRIDE);

   if (STRIDE < 1 || (STRIDE & (STRIDE - 1)) != 0) begin : g_bad_stride
      $error("STRIDE must be a power of two");
   end

   typedef enum logic [2:0] {IDLE, LOAD_LEN, LOAD_ADDR, ISSUE, DONE} state_t;
   state_t state, nxt;

   logic [1:0]        mode_q;
   logic [LEN_W-1:0]  len, beat;
   logic [ADDR_W-2:0] sh;
   logic [ADDR_W-1:0] mask, adv;
   logic [BW-1:0]     bcnt;
   logic              wrap, len_end, addr_end, bad_len, accept;

   assign wrap       = mode_q == 2'b10;
   assign len_end    = bcnt == BW'(LEN_W - 1);
   assign addr_end   = bcnt == BW'(ADDR_W - 1);
   // beats = len+1 is a power of two exactly when len and len+1 share no set bits
   assign bad_len    = wrap & |(len & (len + 1'b1));
   assign addr_valid = state == ISSUE;
   assign last       = addr_valid & (beat == len);
   assign busy       = state != IDLE;
   assign done       = state == DONE;
   assign accept     = en & addr_valid & addr_ready;
   // wrap window covers beats*STRIDE bytes, aligned to its own size
   assign mask       = ((ADDR_W'(len) + 1'b1) << SH) - 1'b1;
   assign adv        = wrap ? (addr_out & ~mask) | ((addr_out + ADDR_W'(STRIDE)) & mask) :
                       mode_q == 2'b01 ? addr_out + ADDR_W'(STRIDE) : addr_out;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next-state decode; en low freezes the FSM
   always_comb begin
      nxt = state;
      if (en)
         case (state)
            IDLE:      nxt = start ? ((mode == 2'b01 || mode == 2'b10) ? LOAD_LEN : LOAD_ADDR) : IDLE;
            LOAD_LEN:  nxt = len_end ? LOAD_ADDR : LOAD_LEN;
            LOAD_ADDR: nxt = addr_end ? (bad_len ? IDLE : ISSUE) : LOAD_ADDR;
            ISSUE:     nxt = (addr_ready & last) ? DONE : ISSUE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
         endcase
   end

   // serial load shifting, address advance on accept, beat count and err pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {mode_q, len, beat, sh, bcnt, addr_out, err} <= '0;
      end else if (en) begin
         err  <= state == LOAD_ADDR && addr_end && bad_len;
         bcnt <= (nxt == state && (state == LOAD_LEN || state == LOAD_ADDR)) ? bcnt + 1'b1 : '0;
         if (state == IDLE && start) begin
            mode_q <= mode;
            len    <= '0;
         end
         if (state == LOAD_LEN) len <= {len[LEN_W-2:0], ser_in};
         if (state == LOAD_ADDR) sh <= {sh[ADDR_W-3:0], ser_in};
         if (state == LOAD_ADDR && addr_end && !bad_len) begin
            addr_out <= {sh, ser_in};
            beat     <= '0;
         end
         if (accept) begin
            addr_out <= adv;
            beat     <= beat + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_burst_addr_gen.sv
// tb_burst_addr_gen: scoreboard bench for burst_addr_gen with an arithmetic reference model of the address sequence
module tb_burst_addr_gen;
   localparam int S = 1;

   logic        clk = 0, rst = 1, en = 0, start = 0, ser_in = 0, addr_ready = 0;
   logic [1:0]  mode = 0;
   logic [15:0] addr_out;
   logic        addr_valid, last, busy, done, err;

   typedef struct {logic [15:0] a; logic l;} beat_t;
   beat_t q[$];
   int    eq[$];
   beat_t e;
   int    checks = 0, failures = 0, cyc = 0, exp_first = -1;
   logic  hold_v = 0, hold_l = 0, exp_done = 0, prev_done = 0, prev_en = 0, prev_err = 0;
   logic [15:0] hold_a = 0;

   burst_addr_gen #(.ADDR_W(16), .LEN_W(4), .STRIDE(S)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .ser_in(ser_in),
      .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
      .last(last), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // cycle counter used to time first-beat and err expectations
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compares DUT outputs against the scoreboard away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if ({addr_out, addr_valid, last, busy, done, err} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state: addr=%h valid=%b last=%b busy=%b done=%b err=%b, all must be 0",
                     addr_out, addr_valid, last, busy, done, err);
         end
         hold_v = 0;
         exp_done = 0;
      end else begin
         if (cyc == exp_first) begin
            checks++;
            if (addr_valid !== 1'b1) begin
               failures++;
               $display("FAIL first_beat_latency: addr_valid=%b at cycle %0d, required 1", addr_valid, cyc);
            end
            exp_first = -1;
         end
         if (hold_v) begin
            checks++;
            if (addr_valid !== 1'b1 || addr_out !== hold_a || last !== hold_l) begin
               failures++;
               $display("FAIL hold_stable: valid=%b addr=%h last=%b, required 1/%h/%b",
                        addr_valid, addr_out, last, hold_a, hold_l);
            end
         end
         if (exp_done) begin
            checks++;
            if (done !== 1'b1) begin
               failures++;
               $display("FAIL done_pulse: done=%b after last beat, required 1", done);
            end
         end else if (done && !(prev_done && !prev_en)) begin
            checks++;
            failures++;
            $display("FAIL done_spurious: done=1 at cycle %0d, required 0", cyc);
         end
         if (err && !(prev_err && !prev_en)) begin
            checks++;
            if (eq.size() == 0 || eq[0] != cyc) begin
               failures++;
               $display("FAIL err_pulse: err=1 at cycle %0d, expected cycle %0d", cyc, eq.size() ? eq[0] : -1);
            end
            if (eq.size()) void'(eq.pop_front());
         end
         if (addr_valid || done) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL busy: busy=%b while valid=%b done=%b, required 1", busy, addr_valid, done);
            end
         end
         exp_done = 0;
         if (addr_valid && addr_ready && en) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: addr=%h last=%b, no beat expected", addr_out, last);
            end else begin
               e = q.pop_front();
               if (addr_out !== e.a || last !== e.l) begin
                  failures++;
                  $display("FAIL beat: addr=%h last=%b, required %h/%b", addr_out, last, e.a, e.l);
               end
               exp_done = e.l;
            end
         end
         hold_v = addr_valid && !(addr_ready && en);
         hold_a = addr_out;
         hold_l = last;
      end
      prev_done = done;
      prev_en   = en;
      prev_err  = err;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random; rst_after >= 0 resets after that many beats
   task automatic run_cmd(input logic [1:0] m, input int ln, input logic [15:0] a,
                          input bit stall_load, input bit stall_issue, input int ready_mode, input int rst_after);
      bit single = (m == 2'b00 || m == 2'b11);
      int l = single ? 0 : ln;
      int beats = l + 1;
      bit bad = (m == 2'b10) && ((beats & (beats - 1)) != 0);
      logic [3:0] lv = ln[3:0];
      int unsigned ai = a, w = beats * S, base, v;
      int k = 0, g = 0;
      if (!bad)
         for (int b = 0; b <= l; b++) begin
            base = ai - ai % w;
            v = single ? ai : (m == 2'b01) ? (ai + b * S) % 65536 : base + (ai - base + b * S) % w;
            q.push_back('{v[15:0], b == l});
         end
      en = 1;
      start = 1;
      mode = m;
      tick();
      start = 0;
      mode = 2'($urandom);
      if (!single)
         for (int i = 3; i >= 0; i--) begin
            ser_in = lv[i];
            tick();
         end
      for (int i = 15; i >= 0; i--) begin
         ser_in = a[i];
         if (stall_load && i == 7) begin
            en = 0;
            repeat (5) tick();
            en = 1;
         end
         tick();
      end
      ser_in = 1'($urandom);
      if (bad) eq.push_back(cyc);
      else exp_first = cyc;
      while (q.size() > 0 && g < 500) begin
         addr_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (k % 3 == 0) : 1'($urandom);
         start = stall_issue && k == 1;
         if (stall_issue && k == 3) begin
            en = 0;
            repeat (5) tick();
            en = 1;
         end
         if (rst_after >= 0 && beats - q.size() >= rst_after) begin
            rst = 1;
            q.delete();
            exp_first = -1;
            tick();
            rst = 0;
            break;
         end
         tick();
         k++;
         g++;
      end
      if (g >= 500) begin
         checks++;
         failures++;
         $display("FAIL timeout: %0d beats still pending, required 0", q.size());
         q.delete();
      end
      addr_ready = 0;
      start = 0;
      repeat (2) tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      tick();
      run_cmd(2'b01, 3, 16'h0010, 0, 0, 0, -1);
      run_cmd(2'b10, 3, 16'h000E, 0, 0, 0, -1);
      run_cmd(2'b10, 2, 16'h0040, 0, 0, 0, -1);
      run_cmd(2'b00, 5, 16'h1234, 0, 0, 0, -1);
      run_cmd(2'b01, 3, 16'hFFFE, 0, 0, 1, -1);
      run_cmd(2'b01, 7, 16'h0100, 1, 1, 0, -1);
      run_cmd(2'b01, 7, 16'h0200, 0, 0, 0, 2);
      run_cmd(2'b11, 0, 16'hBEEF, 0, 0, 0, -1);
      run_cmd(2'b10, 15, 16'hFFF7, 0, 0, 2, -1);
      repeat (30)
         run_cmd(2'($urandom), int'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), -1);
      checks++;
      if (q.size() != 0 || eq.size() != 0) begin
         failures++;
         $display("FAIL drain: beats=%0d errs=%0d left over, required 0/0", q.size(), eq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
